// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU slice: data width and one-hot opcodes.
package alu_pkg;

  localparam int WIDTH = 8;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000100;
  localparam logic [5:0] OP_XOR = 6'b001000;
  localparam logic [5:0] OP_SUB = 6'b010000;
  localparam logic [5:0] OP_NOT = 6'b100000;

endpackage

// File: rtl/alu_addsub.sv
// Combinational 8-bit adder/subtractor shared by ADD and SUB.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   sum;

  // Subtraction is a + ~b + ~borrow_in; the inverted carry is the borrow out.
  assign b_eff  = sub ? ~b : b;
  assign c_eff  = sub ? ~cin : cin;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
  assign result = sum[WIDTH-1:0];
  assign cout   = sub ? ~sum[WIDTH] : sum[WIDTH];

endmodule

// File: rtl/alu.sv
// Registered 8-bit ALU slice with carry/borrow chaining for the 16-bit controller.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       op,
  input  logic             en,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic             is_sub;
  logic [WIDTH-1:0] as_result;
  logic             as_cout;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_cout;

  assign is_sub = (op == OP_SUB);

  alu_addsub u_addsub (
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sub    (is_sub),
    .result (as_result),
    .cout   (as_cout)
  );

  // Zero, multi-hot and unknown opcodes all fall through to the zero default.
  always_comb begin
    nxt_result = '0;
    nxt_cout   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        nxt_result = as_result;
        nxt_cout   = as_cout;
      end
      OP_AND: nxt_result = a & b;
      OP_OR:  nxt_result = a | b;
      OP_XOR: nxt_result = a ^ b;
      OP_NOT: nxt_result = ~a;
      default: begin
        nxt_result = '0;
        nxt_cout   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      cout   <= 1'b0;
    end else if (en) begin
      result <= nxt_result;
      cout   <= nxt_cout;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the alu slice: directed boundaries plus random traffic.
module tb_alu;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [5:0] op;
  logic       en;
  logic       cin;
  logic [7:0] result;
  logic       cout;

  int n_checks;
  int n_errors;
  logic [8:0] exp_q;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .op     (op),
    .en     (en),
    .cin    (cin),
    .result (result),
    .cout   (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the operation's definition.
  function automatic logic [8:0] model(input logic [5:0] o, input logic [7:0] x,
                                       input logic [7:0] y, input logic c);
    int s;
    if ($isunknown(o)) return 9'h000;
    if (o == OP_ADD) begin
      s = int'(x) + int'(y) + int'(c);
      return s[8:0];
    end
    if (o == OP_SUB) begin
      s = int'(x) - int'(y) - int'(c);
      return {(s < 0), s[7:0]};
    end
    if (o == OP_AND) return {1'b0, x & y};
    if (o == OP_OR)  return {1'b0, x | y};
    if (o == OP_XOR) return {1'b0, x ^ y};
    if (o == OP_NOT) return {1'b0, ~x};
    return 9'h000;
  endfunction

  // Drive inputs away from the edge, clock once, compare on the falling edge.
  task automatic apply(input string tag, input logic [5:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic c, input logic e, input logic r);
    op = o; a = x; b = y; cin = c; en = e; rst = r;
    if (r) exp_q = 9'h000;
    else if (e) exp_q = model(o, x, y, c);
    @(posedge clk);
    @(negedge clk);
    check(tag, {23'd0, cout, result}, {23'd0, exp_q});
  endtask

  task automatic chain(input string tag, input logic [5:0] o, input logic [15:0] x,
                       input logic [15:0] y, output logic [15:0] r, output logic c);
    apply({tag, "_lo"}, o, x[7:0], y[7:0], 1'b0, 1'b1, 1'b0);
    r[7:0] = result;
    apply({tag, "_hi"}, o, x[15:8], y[15:8], cout, 1'b1, 1'b0);
    r[15:8] = result;
    c = cout;
  endtask

  initial begin
    logic [15:0] r16;
    logic        c16;
    logic [5:0]  ro;
    n_checks = 0;
    n_errors = 0;
    exp_q = 9'h000;
    rst = 1'b1; en = 1'b1; op = OP_ADD; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(negedge clk);

    apply("reset0", OP_ADD, 8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
    apply("reset1", OP_ADD, 8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
    apply("first_add", OP_ADD, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
    check("first_add_const", {23'd0, cout, result}, 32'h046);

    apply("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    check("add_ff_01_const", {23'd0, cout, result}, 32'h100);
    apply("add_80_7f_c", OP_ADD, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0);
    apply("add_ff_ff_c", OP_ADD, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
    check("add_ff_ff_c_const", {23'd0, cout, result}, 32'h1FF);

    apply("sub_03_05", OP_SUB, 8'h03, 8'h05, 1'b0, 1'b1, 1'b0);
    check("sub_03_05_const", {23'd0, cout, result}, 32'h1FE);
    apply("sub_05_03_b", OP_SUB, 8'h05, 8'h03, 1'b1, 1'b1, 1'b0);
    apply("sub_00_01", OP_SUB, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
    apply("sub_05_05_b", OP_SUB, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0);
    check("sub_05_05_b_const", {23'd0, cout, result}, 32'h1FF);
    apply("sub_aa_aa", OP_SUB, 8'hAA, 8'hAA, 1'b0, 1'b1, 1'b0);

    apply("and", OP_AND, 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0);
    check("and_const", {23'd0, cout, result}, 32'h030);
    apply("or",  OP_OR,  8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0);
    apply("xor", OP_XOR, 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0);
    apply("not", OP_NOT, 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0);
    check("not_const", {23'd0, cout, result}, 32'h00F);
    apply("multi_hot", 6'b000011, 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0);
    apply("op_zero", 6'b000000, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
    apply("op_x", 6'bxxxxxx, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);

    apply("hold_load", OP_ADD, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      apply("hold", OP_SUB, 8'(i * 7 + 1), 8'hC3, 1'b1, 1'b0, 1'b0);
    check("hold_const", {23'd0, cout, result}, 32'h030);
    apply("reenable", OP_XOR, 8'h5A, 8'hA5, 1'b0, 1'b1, 1'b0);

    chain("chain_sub", OP_SUB, 16'h1234, 16'h2345, r16, c16);
    check("chain_sub_val", {15'd0, c16, r16}, {15'd0, 1'b1, 16'hEEEF});
    check("chain_sub_mag", 32'd65536 - {16'd0, r16}, 32'h1111);
    chain("chain_add", OP_ADD, 16'h00FF, 16'h0001, r16, c16);
    check("chain_add_val", {15'd0, c16, r16}, {15'd0, 1'b0, 16'h0100});

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: ro = OP_ADD;
        1: ro = OP_AND;
        2: ro = OP_OR;
        3: ro = OP_XOR;
        4: ro = OP_SUB;
        5: ro = OP_NOT;
        6: ro = 6'($urandom);
        default: ro = OP_SUB;
      endcase
      apply("random", ro, 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
